// File: rtl/axi_slice_stream_arbiter_pkg.sv
// Shared types and helpers for the burst-locking round-robin arbiter
// that sits in front of a single-slice valid/ready buffer.
package axi_slice_arb_pkg;

    // Width of a requester index. A single requester still gets one bit,
    // so every index port has a legal, non-zero width.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Arbiter lock state: a grant is either free for re-arbitration or
    // pinned to one requester until its burst ends.
    typedef enum logic {
        ARB_UNLOCKED = 1'b0,
        ARB_LOCKED   = 1'b1
    } arb_state_e;

endpackage

// File: rtl/axi_slice_stream_arbiter_rr_prio.sv
// Rotating priority encoder: returns the first asserted request found
// when searching upward from ptr_i and wrapping from NUM_IN-1 back to 0.
// Purely combinational; any_o reports whether any request is present.
module axi_slice_rr_prio
    import axi_slice_arb_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int IDX_W  = idx_width(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req_i,
    input  logic [IDX_W-1:0]  ptr_i,
    output logic [IDX_W-1:0]  idx_o,
    output logic              any_o
);

    // Requests padded to the full index range so every index value
    // addresses a real bit; the padding bits are never set.
    localparam int                PAD_N = 1 << IDX_W;
    localparam logic [IDX_W:0]    NUM_W = (IDX_W + 1)'(NUM_IN);

    logic [PAD_N-1:0] reqPad;
    logic [IDX_W:0]   cand;

    assign reqPad = PAD_N'(req_i);

    // Walk the offsets from farthest to nearest so the request closest to
    // the pointer is the one left standing. The candidate carries one extra
    // bit so ptr+offset cannot overflow before the explicit wrap.
    always_comb begin
        idx_o = '0;
        any_o = |req_i;
        cand  = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_i} + (IDX_W + 1)'(k);
            if (cand >= NUM_W) begin
                cand = cand - NUM_W;
            end
            if (reqPad[cand[IDX_W-1:0]]) begin
                idx_o = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/axi_slice_stream_arbiter.sv
// Burst-locking round-robin arbiter feeding one shared valid/ready slice.
// A requester that wins keeps the grant until its last beat is accepted,
// so bursts never interleave downstream. The datapath is combinational;
// only the lock, the held selection and the round-robin pointer are stored.
module axi_slice_stream_arbiter
    import axi_slice_arb_pkg::*;
#(
    parameter int NUM_IN     = 4,
    parameter int DATA_WIDTH = 64,
    parameter int IDX_W      = idx_width(NUM_IN)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_IN-1:0]            in_valid_i,
    output logic [NUM_IN-1:0]            in_ready_o,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data_i,
    input  logic [NUM_IN-1:0]            in_last_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [DATA_WIDTH-1:0]        out_data_o,
    output logic                         out_last_o,
    output logic [IDX_W-1:0]             out_idx_o,
    output logic                         locked_o
);

    localparam int               PAD_N    = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);

    arb_state_e             state_q;
    logic [IDX_W-1:0]       sel_q;
    logic [IDX_W-1:0]       rr_ptr_q;
    logic [IDX_W-1:0]       rr_ptr_d;

    logic [PAD_N-1:0]       validPad;
    logic [IDX_W-1:0]       prioIdx;
    logic                   prioAny;
    logic [IDX_W-1:0]       selIdx;
    logic                   selValid;
    logic [DATA_WIDTH-1:0]  selData;
    logic                   selLast;
    logic                   outValid;
    logic                   handshake;

    // Padded valid vector so the held index can be looked up directly even
    // when NUM_IN is not a power of two.
    assign validPad = PAD_N'(in_valid_i);

    axi_slice_rr_prio #(
        .NUM_IN (NUM_IN),
        .IDX_W  (IDX_W)
    ) u_rr_prio (
        .req_i  (in_valid_i),
        .ptr_i  (rr_ptr_q),
        .idx_o  (prioIdx),
        .any_o  (prioAny)
    );

    // Choose who is offered downstream: the held requester while locked,
    // otherwise the round-robin winner. A locked requester that drops valid
    // simply produces no offer; nobody else is allowed in mid-burst.
    always_comb begin
        selIdx   = prioIdx;
        selValid = prioAny;
        if (state_q == ARB_LOCKED) begin
            selIdx   = sel_q;
            selValid = validPad[sel_q];
        end
    end

    // Payload mux. Defaults keep the outputs X-free when nothing is offered.
    always_comb begin
        selData = '0;
        selLast = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (selIdx == IDX_W'(i)) begin
                selData = in_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                selLast = in_last_i[i];
            end
        end
    end

    // The handshake is only visible while out of reset, so upstream and the
    // slice see a quiet interface during the reset cycle(s).
    assign outValid  = rst_ni & selValid;
    assign handshake = outValid & out_ready_i;

    // Ready is steered back to the selected requester only.
    always_comb begin
        in_ready_o = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            in_ready_o[i] = out_ready_i & outValid & (selIdx == IDX_W'(i));
        end
    end

    // Next round-robin start: one past the requester finishing its burst,
    // wrapping explicitly so non-power-of-two counts stay in range.
    assign rr_ptr_d = (selIdx == LAST_IDX) ? '0 : selIdx + IDX_W'(1);

    // Lock FSM. An offer that is not completed by a last-beat handshake pins
    // the selection, which also keeps a stalled single beat stable. The
    // pointer only moves when a burst finishes.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ARB_UNLOCKED;
            sel_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            case (state_q)
                ARB_UNLOCKED: begin
                    if (selValid) begin
                        if (handshake && selLast) begin
                            rr_ptr_q <= rr_ptr_d;
                        end else begin
                            state_q <= ARB_LOCKED;
                            sel_q   <= selIdx;
                        end
                    end
                end
                ARB_LOCKED: begin
                    if (handshake && selLast) begin
                        state_q  <= ARB_UNLOCKED;
                        rr_ptr_q <= rr_ptr_d;
                    end
                end
                default: begin
                    state_q <= ARB_UNLOCKED;
                end
            endcase
        end
    end

    // Output assignments; the lock indication is masked while in reset.
    assign out_valid_o = outValid;
    assign out_data_o  = selData;
    assign out_last_o  = selLast;
    assign out_idx_o   = selIdx;
    assign locked_o    = rst_ni & (state_q == ARB_LOCKED);

endmodule

// File: tb/tb_axi_slice_stream_arbiter.sv
// Scoreboard bench for the burst-locking round-robin arbiter. Per-requester
// burst sources feed the DUT; a reference model predicts every cycle's
// offer/ready/lock and every accepted beat, and a monitor compares.
module tb_axi_slice_stream_arbiter;

    localparam int NUM_IN = 4;
    localparam int DW     = 64;
    localparam int IW     = 2;

    typedef struct {
        logic [DW-1:0] data;
        bit            last;
        int            gap;
    } beat_t;

    typedef struct {
        bit                valid;
        logic [NUM_IN-1:0] ready;
        bit                locked;
    } ctrl_t;

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
        bit            last;
    } exp_beat_t;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic [NUM_IN-1:0]     in_valid_i;
    logic [NUM_IN-1:0]     in_ready_o;
    logic [NUM_IN*DW-1:0]  in_data_i;
    logic [NUM_IN-1:0]     in_last_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [DW-1:0]         out_data_o;
    logic                  out_last_o;
    logic [IW-1:0]         out_idx_o;
    logic                  locked_o;

    // Upstream burst sources, their inter-beat gap counters and the
    // expectation queues shared between stimulus and monitor.
    beat_t     srcQ [NUM_IN][$];
    int        gapCnt [NUM_IN];
    int        burstSeq [NUM_IN];
    ctrl_t     ctrlQ [$];
    exp_beat_t beatQ [$];

    // Reference model state: who owns the channel and where the next
    // round-robin search begins.
    bit mLocked;
    int mOwner;
    int mPtr;

    int nVectors     = 0;
    int nMiscompares = 0;
    bit finishReq    = 1'b0;
    bit monDone      = 1'b0;

    always #5 clk_i = ~clk_i;

    axi_slice_stream_arbiter #(
        .NUM_IN     (NUM_IN),
        .DATA_WIDTH (DW)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_last_i   (in_last_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .out_idx_o   (out_idx_o),
        .locked_o    (locked_o)
    );

    // One comparison; every miscompare prints a single FAIL line.
    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        nVectors++;
        if (got !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
        end
    endtask

    task automatic pushBeat(input int r, input logic [DW-1:0] data, input bit last, input int gap);
        beat_t b;
        b.data = data;
        b.last = last;
        b.gap  = gap;
        srcQ[r].push_back(b);
    endtask

    function automatic bit anyPending();
        bit p = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (srcQ[i].size() > 0) p = 1'b1;
        end
        return p;
    endfunction

    // Drive one cycle: present each source's head beat (after its gap),
    // predict the outcome from the arbitration rules, queue expectations,
    // then advance the model and the sources across the clock edge.
    task automatic applyStimulus(input bit rstn, input bit rdy);
        logic [NUM_IN-1:0] v;
        logic [NUM_IN-1:0] l;
        logic [NUM_IN-1:0] er;
        logic [DW-1:0]     d [NUM_IN];
        int                sel;
        bit                ev;
        ctrl_t             c;
        exp_beat_t         b;

        if (!rstn) begin
            for (int i = 0; i < NUM_IN; i++) begin
                srcQ[i].delete();
                gapCnt[i] = 0;
            end
        end
        for (int i = 0; i < NUM_IN; i++) begin
            v[i] = 1'b0;
            l[i] = 1'b0;
            d[i] = '0;
            if (srcQ[i].size() > 0) begin
                d[i] = srcQ[i][0].data;
                l[i] = srcQ[i][0].last;
                v[i] = (gapCnt[i] >= srcQ[i][0].gap);
            end
        end

        rst_ni      = rstn;
        out_ready_i = rdy;
        in_valid_i  = v;
        in_last_i   = l;
        for (int i = 0; i < NUM_IN; i++) begin
            in_data_i[i*DW +: DW] = d[i];
        end

        sel = 0;
        ev  = 1'b0;
        if (mLocked) begin
            sel = mOwner;
            ev  = v[sel];
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                int j;
                j = (mPtr + k) % NUM_IN;
                if (!ev && v[j]) begin
                    ev  = 1'b1;
                    sel = j;
                end
            end
        end
        if (!rstn) ev = 1'b0;

        er = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            er[i] = rdy && ev && (i == sel);
        end
        c.valid  = ev;
        c.ready  = er;
        c.locked = rstn && mLocked;
        ctrlQ.push_back(c);
        if (ev && rdy) begin
            b.idx  = sel;
            b.data = d[sel];
            b.last = l[sel];
            beatQ.push_back(b);
        end

        @(posedge clk_i);

        if (!rstn) begin
            mLocked = 1'b0;
            mOwner  = 0;
            mPtr    = 0;
        end else if (ev) begin
            if (rdy && l[sel]) begin
                mLocked = 1'b0;
                mPtr    = (sel + 1) % NUM_IN;
            end else begin
                mLocked = 1'b1;
                mOwner  = sel;
            end
        end

        for (int i = 0; i < NUM_IN; i++) begin
            if (er[i]) begin
                void'(srcQ[i].pop_front());
                gapCnt[i] = 0;
            end else if (srcQ[i].size() > 0 && !v[i]) begin
                gapCnt[i]++;
            end
        end
        #1;
    endtask

    // Keep clocking with the slice ready until every source has drained.
    task automatic runUntilDrained(input int maxCycles);
        int n = 0;
        while (anyPending() && n < maxCycles) begin
            applyStimulus(1'b1, 1'b1);
            n++;
        end
        if (anyPending()) begin
            $display("[TB] FAIL drain: sources still pending after %0d cycles", maxCycles);
            $fatal(1, "[TB] drain bound expired");
        end
    endtask

    // Monitor: each cycle compare the predicted control view, check the
    // payload is X-free, and pop the next expected beat on every DUT handshake.
    initial begin
        ctrl_t     c;
        exp_beat_t e;
        forever begin
            @(negedge clk_i);
            if (ctrlQ.size() > 0) begin
                c = ctrlQ.pop_front();
                checkOutput("out_valid", 64'(out_valid_o), 64'(c.valid));
                checkOutput("in_ready", 64'(in_ready_o), 64'(c.ready));
                checkOutput("locked", 64'(locked_o), 64'(c.locked));
                checkOutput("xfree", 64'($isunknown({out_data_o, out_last_o, out_idx_o})), 64'(0));
            end
            if (out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
                if (beatQ.size() == 0) begin
                    checkOutput("beat_expected", 64'(beatQ.size()), 64'(1));
                end else begin
                    e = beatQ.pop_front();
                    checkOutput("out_idx", 64'(out_idx_o), 64'(e.idx));
                    checkOutput("out_data", out_data_o, e.data);
                    checkOutput("out_last", 64'(out_last_o), 64'(e.last));
                end
            end
            if (finishReq && !monDone) begin
                checkOutput("ctrl_drained", 64'(ctrlQ.size()), 64'(0));
                checkOutput("beats_drained", 64'(beatQ.size()), 64'(0));
                monDone = 1'b1;
            end
        end
    end

    // Directed scenarios first, then a long randomized run with random
    // backpressure, gaps, burst lengths and occasional resets.
    initial begin
        rst_ni      = 1'b0;
        out_ready_i = 1'b0;
        in_valid_i  = '0;
        in_last_i   = '0;
        in_data_i   = '0;
        mLocked     = 1'b0;
        mOwner      = 0;
        mPtr        = 0;
        for (int i = 0; i < NUM_IN; i++) begin
            gapCnt[i]   = 0;
            burstSeq[i] = 0;
        end
        @(posedge clk_i);
        #1;

        $display("[TB] reset and idle");
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        repeat (10) applyStimulus(1'b1, 1'b1);

        $display("[TB] single-beat alternation between 0 and 2");
        pushBeat(0, 64'hA0, 1'b1, 0);
        pushBeat(0, 64'hA0, 1'b1, 0);
        pushBeat(2, 64'hA2, 1'b1, 0);
        pushBeat(2, 64'hA2, 1'b1, 0);
        runUntilDrained(20);

        $display("[TB] 3-beat burst on 1 with 3 contending");
        applyStimulus(1'b0, 1'b1);
        pushBeat(1, 64'h11, 1'b0, 0);
        pushBeat(1, 64'h12, 1'b0, 0);
        pushBeat(1, 64'h13, 1'b1, 0);
        pushBeat(3, 64'h33, 1'b1, 0);
        pushBeat(3, 64'h33, 1'b1, 0);
        runUntilDrained(20);

        $display("[TB] backpressure on a single beat");
        pushBeat(0, 64'h55, 1'b1, 0);
        pushBeat(1, 64'h66, 1'b1, 1);
        repeat (5) applyStimulus(1'b1, 1'b0);
        runUntilDrained(20);

        $display("[TB] locked requester drops valid mid-burst");
        applyStimulus(1'b0, 1'b1);
        pushBeat(2, 64'h21, 1'b0, 0);
        pushBeat(2, 64'h22, 1'b0, 0);
        pushBeat(2, 64'h23, 1'b1, 3);
        pushBeat(0, 64'h05, 1'b1, 1);
        pushBeat(0, 64'h06, 1'b1, 0);
        runUntilDrained(30);

        $display("[TB] reset mid-burst");
        pushBeat(3, 64'h31, 1'b0, 0);
        pushBeat(3, 64'h32, 1'b0, 0);
        pushBeat(3, 64'h33, 1'b1, 0);
        pushBeat(0, 64'h07, 1'b1, 2);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        pushBeat(0, 64'h08, 1'b1, 0);
        pushBeat(3, 64'h34, 1'b1, 0);
        runUntilDrained(10);

        $display("[TB] randomized traffic");
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (srcQ[i].size() == 0 && $urandom_range(0, 3) == 0) begin
                    int len;
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) begin
                        pushBeat(i, {32'($urandom), 8'(i), 8'(burstSeq[i]), 16'(b)},
                                 (b == len - 1),
                                 ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0);
                    end
                    burstSeq[i]++;
                end
            end
            applyStimulus($urandom_range(0, 499) != 0, $urandom_range(0, 9) < 7);
        end

        finishReq = 1'b1;
        for (int k = 0; k < 10 && !monDone; k++) @(negedge clk_i);
        if (!monDone) begin
            $display("[TB] FAIL monitor: final checks never ran");
            $fatal(1, "[TB] monitor stalled");
        end
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
